// File: rtl/cla_addsub_pkg.sv
// Shared types and constants for the nibble-serial CLA add/sub sequencer.
package cla_addsub_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   // Returns 0 for an unusable width so the top level can refuse to elaborate.
   function automatic int nibbles(input int width);
      return ((width % NIBBLE_W) == 0 && width >= NIBBLE_W) ? (width / NIBBLE_W) : 0;
   endfunction

endpackage

// File: rtl/cla_addsub_sequencer_if.sv
// Operand/result handshake bundle for cla_addsub_sequencer.
// Carries ovf_o only when SIGNED_OVF_EN is defined.
interface cla_addsub_sequencer_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             cin_i;
   logic             sub_i;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum_o;
   logic             cout_o;
   logic             busy_o;
`ifdef SIGNED_OVF_EN
   logic             ovf_o;
`endif

   modport master (
      output in_valid, a_i, b_i, cin_i, sub_i, out_ready,
      input  in_ready, out_valid, sum_o, cout_o, busy_o
`ifdef SIGNED_OVF_EN
      , ovf_o
`endif
   );

   modport slave (
      input  in_valid, a_i, b_i, cin_i, sub_i, out_ready,
      output in_ready, out_valid, sum_o, cout_o, busy_o
`ifdef SIGNED_OVF_EN
      , ovf_o
`endif
   );

endinterface

// File: rtl/cla_nibble_slice.sv
// Combinational 4-bit carry-lookahead adder slice; b arrives pre-inverted for subtract.
module cla_nibble_slice
   import cla_addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co,
   output logic                c3
);

   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic                c1;
   logic                c2;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is flattened into generate/propagate terms so no ripple path exists.
   assign c1 = g[0] | (p[0] & ci);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & ci);

   assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_addsub_sequencer.sv
// Nibble-serial multi-precision add/subtract around one CLA slice, LSB nibble first.
// Optional two's-complement overflow flag ovf_o when SIGNED_OVF_EN is defined.
module cla_addsub_sequencer
   import cla_addsub_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input logic                   clk,
   input logic                   rst_n,
   cla_addsub_sequencer_if.slave bus
);

   localparam int NIBBLES = nibbles(WIDTH);
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST     = IDX_W'(NIBBLES - 1);
   localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

   if (NIBBLES == 0) begin : g_bad_width
      $error("cla_addsub_sequencer: WIDTH must be a multiple of 4 and at least 4");
   end

   seq_state_t       state;
   seq_state_t       state_n;
   logic [IDX_W-1:0] idx;
   logic [IDX_W+1:0] sh;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             sub_reg;
   logic             carry;
   logic             cout_reg;
   logic [3:0]       s_nib;
   logic             slice_co;
   logic             slice_c3;

   assign sh   = {idx, 2'b00};
   assign a_sh = a_reg >> sh;
   assign b_sh = b_reg >> sh;

   cla_nibble_slice u_slice (
      .a  (a_sh[NIBBLE_W-1:0]),
      .b  (b_sh[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_reg}}),
      .ci (carry),
      .s  (s_nib),
      .co (slice_co),
      .c3 (slice_c3)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy_o    = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_n = RUN;
         end
         RUN: begin
            bus.busy_o = 1'b1;
            if (idx == LAST) state_n = DONE;
         end
         DONE: begin
            bus.busy_o    = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Subtract reuses the adder as A + ~B + 1, so the carry seeds to 1 regardless of cin_i.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sub_reg  <= 1'b0;
         carry    <= 1'b0;
         idx      <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         a_reg   <= bus.a_i;
         b_reg   <= bus.b_i;
         sub_reg <= bus.sub_i;
         carry   <= bus.sub_i | bus.cin_i;
         idx     <= '0;
      end else if (state == RUN) begin
         sum_reg <= (sum_reg & ~(NIB_MASK << sh)) | (WIDTH'(s_nib) << sh);
         carry   <= slice_co;
         if (idx == LAST) cout_reg <= slice_co;
         else             idx      <= idx + 1'b1;
      end
   end

   assign bus.sum_o  = sum_reg;
   assign bus.cout_o = cout_reg;

`ifdef SIGNED_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             ovf_reg <= 1'b0;
      else if (state == RUN && idx == LAST)   ovf_reg <= slice_co ^ slice_c3;
   end

   assign bus.ovf_o = ovf_reg;
`else
   logic ovf_unused;
   assign ovf_unused = slice_c3;
`endif

endmodule
